// File: rtl/sample2_responder.sv
// Request/response responder: captures a transformed copy of each request,
// holds it for a programmable latency, then presents it until the consumer takes it.
module sample2_responder #(
   parameter bit [3:0] param1 = 4'd5,
   parameter int       param2 = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              sigo1,
   input  logic [3:0]        sigo3,
   input  logic [4:0]        sigo4,
   input  logic [3:0]        sigo7 [0:3],
   output logic              sigi1,
   output logic [3:0]        sigi3,
   output logic [4:0]        sigi4,
   output logic [3:0]        sigi7 [0:3],
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [param2-1:0] txn_cnt,
   output logic              busy
);

   // A zero latency setting is promoted to one cycle.
   localparam logic [3:0]        LAT     = (param1 == 4'd0) ? 4'd1 : param1;
   localparam logic [param2-1:0] CNT_ONE = {{(param2-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [3:0]          r_wait_cnt;
   logic [param2-1:0]   r_txn_cnt;
   logic                r_sigi1;
   logic [3:0]          r_sigi3;
   logic [4:0]          r_sigi4;
   logic [3:0]          r_sigi7 [0:3];

   logic                w_accept;
   logic                w_rsp_hs;
   logic [4:0]          w_sigi4;
   logic [3:0]          w_sigi7 [0:3];

   assign w_accept = (r_state == IDLE) && req_valid;
   assign w_rsp_hs = (r_state == RESP) && rsp_ready;

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_rev4
         assign w_sigi4[gi] = sigo4[4-gi];
      end
      for (genvar gi = 0; gi < 4; gi++) begin : g_rev7
         assign w_sigi7[gi] = sigo7[3-gi];
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (req_valid)            w_state_next = WAIT;
         WAIT:    if (r_wait_cnt == 4'd1)   w_state_next = RESP;
         RESP:    if (rsp_ready)            w_state_next = IDLE;
         default:                           w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= IDLE;
         r_wait_cnt <= 4'd0;
         r_txn_cnt  <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_wait_cnt <= LAT;
         end else if (r_state == WAIT && r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
         end
         if (w_rsp_hs) begin
            r_txn_cnt <= r_txn_cnt + CNT_ONE;
         end
      end
   end

   // Response fields change only on acceptance, so they stay put through
   // back-pressure and after the handshake.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sigi1 <= 1'b0;
         r_sigi3 <= 4'd0;
         r_sigi4 <= 5'd0;
         for (int i = 0; i < 4; i++) begin
            r_sigi7[i] <= 4'd0;
         end
      end else if (w_accept) begin
         r_sigi1 <= ~sigo1;
         r_sigi3 <= sigo3 + 4'd1;
         r_sigi4 <= w_sigi4;
         for (int i = 0; i < 4; i++) begin
            r_sigi7[i] <= w_sigi7[i];
         end
      end
   end

   assign req_ready = (r_state == IDLE);
   assign rsp_valid = (r_state == RESP);
   assign busy      = (r_state == WAIT) || (r_state == RESP);
   assign txn_cnt   = r_txn_cnt;
   assign sigi1     = r_sigi1;
   assign sigi3     = r_sigi3;
   assign sigi4     = r_sigi4;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_out7
         assign sigi7[gi] = r_sigi7[gi];
      end
   endgenerate

endmodule

// File: tb/tb_sample2_responder.sv
// Directed bench for sample2_responder: default build plus a param1=0/param2=2 build.
module tb_sample2_responder;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        sigo1 = 1'b0;
   logic [3:0]  sigo3 = 4'd0;
   logic [4:0]  sigo4 = 5'd0;
   logic [3:0]  sigo7 [0:3];

   // default instance
   logic        req_valid = 1'b0, rsp_ready = 1'b0;
   logic        req_ready, rsp_valid, busy, sigi1;
   logic [3:0]  sigi3;
   logic [4:0]  sigi4;
   logic [3:0]  sigi7 [0:3];
   logic [31:0] txn_cnt;
   logic [15:0] s7;

   // param1=0, param2=2 instance
   logic        req_valid_b = 1'b0, rsp_ready_b = 1'b0;
   logic        req_ready_b, rsp_valid_b, busy_b, sigi1_b;
   logic [3:0]  sigi3_b;
   logic [4:0]  sigi4_b;
   logic [3:0]  sigi7_b [0:3];
   logic [1:0]  txn_cnt_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign s7 = {sigi7[0], sigi7[1], sigi7[2], sigi7[3]};

   sample2_responder u_dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
      .sigo1(sigo1), .sigo3(sigo3), .sigo4(sigo4), .sigo7(sigo7),
      .sigi1(sigi1), .sigi3(sigi3), .sigi4(sigi4), .sigi7(sigi7),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .txn_cnt(txn_cnt), .busy(busy)
   );

   sample2_responder #(.param1(4'd0), .param2(2)) u_dut_b (
      .clk(clk), .rstn(rstn), .req_valid(req_valid_b), .req_ready(req_ready_b),
      .sigo1(sigo1), .sigo3(sigo3), .sigo4(sigo4), .sigo7(sigo7),
      .sigi1(sigi1_b), .sigi3(sigi3_b), .sigi4(sigi4_b), .sigi7(sigi7_b),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .txn_cnt(txn_cnt_b), .busy(busy_b)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic o1, input logic [3:0] o3, input logic [4:0] o4,
                          input logic [15:0] o7);
      sigo1 = o1;
      sigo3 = o3;
      sigo4 = o4;
      for (int i = 0; i < 4; i++) sigo7[i] = o7[15-4*i -: 4];
   endtask

   initial begin
      int n;
      int acc_t[$];
      logic prev_ready;

      set_req(1'b0, 4'd0, 5'd0, 16'h0000);
      // ---- reset state
      tick();
      tick();
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_txn_cnt", 64'(txn_cnt), 64'd0);
      chk("rst_sigi", 64'({sigi1, sigi3, sigi4, s7}), 64'd0);
      rstn = 1'b1;
      tick();
      chk("rst_req_ready", 64'(req_ready), 64'd1);

      // ---- basic transaction, latency 5
      set_req(1'b0, 4'h3, 5'b00011, 16'h1234);
      req_valid = 1'b1;
      rsp_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("t1_busy_after_accept", 64'(busy), 64'd1);
      chk("t1_req_ready_low", 64'(req_ready), 64'd0);
      n = 0;
      while (!rsp_valid && n < 20) begin tick(); n++; end
      chk("t1_latency", 64'(n), 64'd5);
      chk("t1_sigi1", 64'(sigi1), 64'd1);
      chk("t1_sigi3", 64'(sigi3), 64'h4);
      chk("t1_sigi4", 64'(sigi4), 64'b11000);
      chk("t1_sigi7", 64'(s7), 64'h4321);
      tick();
      chk("t1_rsp_done", 64'(rsp_valid), 64'd0);
      chk("t1_txn_cnt", 64'(txn_cnt), 64'd1);
      chk("t1_sigi_held", 64'({sigi1, sigi3, sigi4, s7}), 64'({1'b1, 4'h4, 5'b11000, 16'h4321}));

      // ---- wrap of field B, back-pressure, ignored requests
      set_req(1'b1, 4'hF, 5'b10110, 16'hABCD);
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      tick();
      set_req(1'b0, 4'h0, 5'b00000, 16'h0000);
      n = 0;
      while (!rsp_valid && n < 20) begin req_valid = ~req_valid; tick(); n++; end
      chk("t2_latency", 64'(n), 64'd5);
      for (int i = 0; i < 7; i++) begin
         req_valid = ~req_valid;
         tick();
         chk("t2_hold_valid", 64'(rsp_valid), 64'd1);
         chk("t2_hold_sigi", 64'({sigi1, sigi3, sigi4, s7}),
             64'({1'b0, 4'h0, 5'b01101, 16'hDCBA}));
      end
      chk("t2_txn_cnt_stall", 64'(txn_cnt), 64'd1);
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      tick();
      chk("t2_rsp_done", 64'(rsp_valid), 64'd0);
      chk("t2_no_same_cycle_accept", 64'(busy), 64'd0);
      chk("t2_txn_cnt", 64'(txn_cnt), 64'd2);
      chk("t2_sigi3_wrap_held", 64'(sigi3), 64'h0);
      tick();
      req_valid = 1'b0;
      chk("t3_accept_next_cycle", 64'(busy), 64'd1);
      chk("t3_sigi3", 64'(sigi3), 64'h1);

      // ---- reset mid-WAIT
      tick();
      tick();
      rstn = 1'b0;
      #1;
      chk("t3_rst_busy", 64'(busy), 64'd0);
      chk("t3_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("t3_rst_txn_cnt", 64'(txn_cnt), 64'd0);
      chk("t3_rst_sigi", 64'({sigi1, sigi3, sigi4, s7}), 64'd0);
      tick();
      rstn = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (rsp_valid || busy) n++;
      end
      chk("t3_no_resp_after_rst", 64'(n), 64'd0);
      chk("t3_txn_cnt_after_rst", 64'(txn_cnt), 64'd0);

      // ---- continuous requests: one acceptance every param1+2 cycles
      set_req(1'b1, 4'h7, 5'b10000, 16'h0F0F);
      req_valid = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         prev_ready = req_ready;
         tick();
         if (prev_ready && busy) acc_t.push_back(i);
         if (busy && req_ready) begin
            bad++; total++;
            $display("FAIL t4_overlap: busy=1 req_ready=1 expected exclusive");
         end
      end
      req_valid = 1'b0;
      chk("t4_acc_count", 64'(acc_t.size()), 64'd6);
      for (int k = 1; k < acc_t.size() && k < 4; k++)
         chk("t4_period", 64'(acc_t[k] - acc_t[k-1]), 64'd7);
      n = 0;
      while (busy && n < 20) begin tick(); n++; end
      chk("t4_drained", 64'(busy), 64'd0);
      chk("t4_txn_cnt", 64'(txn_cnt), 64'd6);

      // ---- param1=0 / param2=2 build: latency 1 and 2-bit counter wrap
      rsp_ready_b = 1'b1;
      for (int k = 0; k < 5; k++) begin
         set_req(1'b0, 4'(4'hE + k), 5'b00001, 16'h1111);
         req_valid_b = 1'b1;
         tick();
         req_valid_b = 1'b0;
         chk("b_not_yet", 64'(rsp_valid_b), 64'd0);
         tick();
         chk("b_latency1", 64'(rsp_valid_b), 64'd1);
         chk("b_sigi3", 64'(sigi3_b), 64'(4'(4'hF + k)));
         tick();
         chk("b_txn_cnt", 64'(txn_cnt_b), 64'((k + 1) % 4));
      end
      chk("b_sigi4", 64'(sigi4_b), 64'b10000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sample2_responder.md
SAMPLE2_RESPONDER -- requirements
Module: sample2_responder

Interface
REQ-001 SHALL have parameter param1, bit [3:0], default 4'd5: response latency in cycles (0 treated as 1).
REQ-002 SHALL have parameter param2, default 32: width of the transaction counter.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rstn  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  request valid.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port sigo1  input  1  request field A.
REQ-008 SHALL have port sigo3  input  4  request field B.
REQ-009 SHALL have port sigo4  input  5  request field C.
REQ-010 SHALL have port sigo7  input  [3:0] x [0:3] unpacked  request array field D.
REQ-011 SHALL have port sigi1  output  1  response field A.
REQ-012 SHALL have port sigi3  output  4  response field B.
REQ-013 SHALL have port sigi4  output  5  response field C.
REQ-014 SHALL have port sigi7  output  [3:0] x [0:3] unpacked  response array field D.
REQ-015 SHALL have port rsp_valid  output  1  response valid.
REQ-016 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-017 SHALL have port txn_cnt  output  param2  completed-response count.
REQ-018 SHALL have port busy  output  1  high in WAIT or RESP.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT, RESP; transitions: IDLE->WAIT on req_valid&&req_ready; WAIT->RESP when wait counter reaches 1; RESP->IDLE on rsp_valid&&rsp_ready.
REQ-020 SHALL drive req_ready=1 only in IDLE; rsp_valid=1 only in RESP; busy=1 in WAIT or RESP.
REQ-021 SHALL, on request handshake, register the transformed response fields in the same edge; sigo* sampled only at that edge.
REQ-022 SHALL compute sigi1 = ~sigo1.
REQ-023 SHALL compute sigi3 = (sigo3 + 1) mod 16; 4'hF wraps to 4'h0.
REQ-024 SHALL compute sigi4 = bit-reversed sigo4 (sigi4[k] = sigo4[4-k]).
REQ-025 SHALL compute sigi7[i] = sigo7[3-i] for i=0..3 (element order reversed, element bits unchanged).
REQ-026 SHALL load wait counter with param1 (1 if param1==0) on acceptance and decrement once per cycle in WAIT; rsp_valid rises exactly max(param1,1) cycles after the acceptance edge.
REQ-027 SHALL hold sigi1/sigi3/sigi4/sigi7 and rsp_valid stable while rsp_valid&&!rsp_ready.
REQ-028 SHALL keep sigi* at last registered values after the response handshake until the next acceptance.
REQ-029 SHALL ignore req_valid outside IDLE (no capture, no queueing); request may be taken the cycle after the RESP->IDLE handshake, not the same cycle.
REQ-030 SHALL increment txn_cnt by 1 on each response handshake, wrapping from all-ones to 0.
REQ-031 SHALL accept rsp_ready asserted before rsp_valid; handshake completes in the first RESP cycle.

Reset
REQ-032 SHALL, on rstn low, asynchronously force state IDLE, wait counter 0, req_ready=1 after reset release (0 not required during reset), rsp_valid=0, busy=0, txn_cnt=0, sigi1=0, sigi3=0, sigi4=0, all sigi7 elements=0.
REQ-033 SHALL abandon any in-flight transaction on reset mid-WAIT or mid-RESP with no response and no txn_cnt increment.
REQ-034 SHALL resume normal operation on the first rising edge after rstn deasserts.

Verification
REQ-035 Default param1=5: request sigo1=0, sigo3=4'h3, sigo4=5'b00011, sigo7={1,2,3,4}, rsp_ready=1 -> rsp_valid 5 cycles after acceptance; sigi1=1, sigi3=4'h4, sigi4=5'b11000, sigi7={4,3,2,1}; txn_cnt=1.
REQ-036 sigo3=4'hF -> sigi3=4'h0; param1=0 build -> rsp_valid 1 cycle after acceptance.
REQ-037 rsp_ready low 7 cycles in RESP -> rsp_valid and sigi* constant throughout; req_valid pulses during WAIT/RESP ignored; txn_cnt increments once.
REQ-038 rstn asserted 2 cycles after acceptance -> all outputs reset values immediately; no rsp_valid after release without new request; txn_cnt=0.
REQ-039 param2=2, 5 back-to-back transactions -> txn_cnt sequence 1,2,3,0,1.
REQ-040 req_valid held high continuously, rsp_ready=1 -> one acceptance per (param1+2)-cycle period, never two requests in flight.
